// File: rtl/irda_pkg.sv
// Shared NEC IR framing definitions used by both transmit and receive paths.
package irda_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LEAD_MARK  = 3'd1,
      LEAD_SPACE = 3'd2,
      BIT_MARK   = 3'd3,
      BIT_SPACE  = 3'd4,
      STOP_MARK  = 3'd5
   } irda_state_t;

   localparam int LEAD_MARK_UNITS  = 16;
   localparam int LEAD_SPACE_UNITS = 8;
   localparam int ONE_SPACE_UNITS  = 3;
   localparam int ZERO_SPACE_UNITS = 1;
   localparam int STOP_UNITS       = 1;
   localparam int FRAME_UNITS      = 121;

   // NEC on-air word, sent LSB first: address, ~address, command, ~command.
   function automatic logic [31:0] nec_word(input logic [7:0] addr, input logic [7:0] cmd);
      return {~cmd, cmd, ~addr, addr};
   endfunction

   function automatic logic is_mark(input irda_state_t s);
      return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
   endfunction

endpackage

// File: rtl/irda_carrier_gen.sv
// 50% duty carrier for IR marks; restarts high on every rising edge of enable,
// holds low (and re-arms high) while enable is low.
import irda_pkg::*;

module irda_carrier_gen #(
   parameter int HALF = 658
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   output logic carrier
);

   localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

   logic [CW-1:0] r_cnt;
   logic          r_level;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
      end else if (!enable) begin
         r_cnt   <= '0;
         r_level <= 1'b1;
      end else if (r_cnt == CW'(HALF - 1)) begin
         r_cnt   <= '0;
         r_level <= ~r_level;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign carrier = r_level & enable;

endmodule

// File: rtl/irda_tx.sv
// NEC IR frame transmitter: start accepted when idle, frame begins 1 cycle later, done pulses after stop mark.
// Define IRDA_TX_CARRIER_EN to modulate marks with the 38 kHz carrier; otherwise ir_out is the baseband envelope.
import irda_pkg::*;

module irda_tx #(
   parameter int UNIT_CYCLES  = 28125,
   parameter int CARRIER_HALF = 658
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] custom_code,
   input  logic [7:0] data_in,
   output logic       busy,
   output logic       done,
   output logic       ir_out
);

   localparam int TW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam logic [TW-1:0] TICK_LOAD = TW'(UNIT_CYCLES - 1);

   irda_state_t r_state, w_state_nxt;
   logic [TW-1:0] r_tick, w_tick_nxt;
   logic [4:0]    r_units, w_units_nxt;
   logic [4:0]    r_bit, w_bit_nxt;
   logic [31:0]   r_word, w_word_nxt;
   logic          r_done, w_done_nxt;

   logic       w_unit_end, w_state_end, w_load, w_mark;
   logic [4:0] w_load_units;

   assign w_unit_end  = (r_tick == '0);
   assign w_state_end = w_unit_end && (r_units == 5'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_tick  <= '0;
         r_units <= '0;
         r_bit   <= '0;
         r_word  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tick  <= w_tick_nxt;
         r_units <= w_units_nxt;
         r_bit   <= w_bit_nxt;
         r_word  <= w_word_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_tick_nxt   = r_tick;
      w_units_nxt  = r_units;
      w_bit_nxt    = r_bit;
      w_word_nxt   = r_word;
      w_done_nxt   = 1'b0;
      w_load       = 1'b0;
      w_load_units = 5'd0;

      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt  = LEAD_MARK;
               w_load       = 1'b1;
               w_load_units = 5'(LEAD_MARK_UNITS - 1);
               w_word_nxt   = nec_word(custom_code, data_in);
               w_bit_nxt    = 5'd0;
            end
         end
         LEAD_MARK: begin
            if (w_state_end) begin
               w_state_nxt  = LEAD_SPACE;
               w_load       = 1'b1;
               w_load_units = 5'(LEAD_SPACE_UNITS - 1);
            end
         end
         LEAD_SPACE: begin
            if (w_state_end) begin
               w_state_nxt  = BIT_MARK;
               w_load       = 1'b1;
               w_load_units = 5'd0;
            end
         end
         BIT_MARK: begin
            if (w_state_end) begin
               w_state_nxt  = BIT_SPACE;
               w_load       = 1'b1;
               w_load_units = r_word[0] ? 5'(ONE_SPACE_UNITS - 1) : 5'(ZERO_SPACE_UNITS - 1);
            end
         end
         BIT_SPACE: begin
            if (w_state_end) begin
               w_load     = 1'b1;
               w_word_nxt = r_word >> 1;
               if (r_bit == 5'd31) begin
                  w_state_nxt  = STOP_MARK;
                  w_load_units = 5'(STOP_UNITS - 1);
               end else begin
                  w_state_nxt  = BIT_MARK;
                  w_load_units = 5'd0;
                  w_bit_nxt    = r_bit + 5'd1;
               end
            end
         end
         STOP_MARK: begin
            if (w_state_end) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      // Counters reload on every state entry and rest at zero in IDLE.
      if (w_load) begin
         w_tick_nxt  = TICK_LOAD;
         w_units_nxt = w_load_units;
      end else if (w_state_nxt == IDLE) begin
         w_tick_nxt  = '0;
         w_units_nxt = '0;
      end else if (w_unit_end) begin
         w_tick_nxt  = TICK_LOAD;
         w_units_nxt = r_units - 5'd1;
      end else begin
         w_tick_nxt = r_tick - 1'b1;
      end
   end

   assign w_mark = is_mark(r_state);
   assign busy   = (r_state != IDLE);
   assign done   = r_done;

`ifdef IRDA_TX_CARRIER_EN
   logic w_carrier;

   irda_carrier_gen #(
      .HALF(CARRIER_HALF)
   ) u_carrier (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (w_mark),
      .carrier(w_carrier)
   );

   assign ir_out = w_mark & w_carrier;
`else
   localparam int unused_carrier_half = CARRIER_HALF;

   assign ir_out = w_mark;
`endif

endmodule

// File: doc/irda_tx.md
IRDA_TX -- requirements
Module: irda_tx

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 28125, meaning clk cycles per 562.5 us NEC base unit at 50 MHz.
REQ-002 SHALL have parameter CARRIER_HALF, default 658, meaning clk cycles per half period of the 38 kHz carrier.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic rises on it.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a frame request sampled on a rising clk edge.
REQ-006 SHALL have port custom_code, input, 8, the NEC address byte.
REQ-007 SHALL have port data_in, input, 8, the NEC command byte.
REQ-008 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse at frame end.
REQ-010 SHALL have port ir_out, output, 1, the IR LED drive; 1 = mark (LED on), 0 = space.

Function
REQ-011 SHALL accept start only when busy=0; start while busy=1 is ignored, with no queuing.
REQ-012 SHALL, on acceptance, latch the 32-bit word {~data_in, data_in, ~custom_code, custom_code} and transmit it bit 0 first (LSB first).
- Inputs may change after the accept cycle without effect on the frame.
REQ-013 SHALL use FSM states IDLE -> LEAD_MARK (16 units) -> LEAD_SPACE (8 units) -> BIT_MARK (1 unit) -> BIT_SPACE (1 unit for a 0, 3 units for a 1) -> BIT_MARK ... after bit 31 -> STOP_MARK (1 unit) -> IDLE.
REQ-014 SHALL raise busy and enter the first mark cycle of ir_out on the clock edge after the accept edge, giving 1-cycle latency.
REQ-015 SHALL hold every frame at exactly 121*UNIT_CYCLES cycles of busy=1, independent of data, because the frame always carries 16 ones and 16 zeros.
REQ-016 SHALL, in the cycle after the last STOP_MARK cycle, set busy=0 and done=1 for one cycle, with ir_out=0.
REQ-017 SHALL accept a start asserted in the done cycle as a new frame, which gives back-to-back frames with no idle gap beyond that cycle.
REQ-018 SHALL count units with a down-counter of width clog2(UNIT_CYCLES) and a unit counter of width 5; neither counter wraps, and both reload on each state entry.
REQ-019 SHALL hold ir_out=0 in IDLE and in every SPACE state.

Reset
REQ-020 SHALL, while rst_n=0, force the following immediately and asynchronously: state=IDLE, busy=0, done=0, ir_out=0, counters=0, shift word=0.
REQ-021 SHALL abandon any frame in progress when reset occurs mid-frame, and SHALL not resume it after rst_n rises.
REQ-022 SHALL accept start no earlier than the first rising clk edge after rst_n deasserts.

Configuration
REQ-023 SHALL, with macro IRDA_TX_CARRIER_EN defined, drive ir_out during mark states as a 50% square wave toggling every CARRIER_HALF cycles.
- The carrier starts high at each mark entry and is forced low in spaces.
REQ-024 SHALL, without IRDA_TX_CARRIER_EN, drive ir_out as a constant 1 for the whole of every mark (baseband envelope), and SHALL contain no carrier logic.

Structure
REQ-025 SHALL take the FSM state enum, LEAD_MARK_UNITS=16, LEAD_SPACE_UNITS=8, ONE_SPACE_UNITS=3, ZERO_SPACE_UNITS=1, STOP_UNITS=1 and FRAME_UNITS=121 from shared package irda_pkg, which the receiver side also uses.
REQ-026 SHALL implement the carrier in sub-module irda_carrier_gen (inputs: clk, rst_n, enable; output: carrier), instantiated only under IRDA_TX_CARRIER_EN.

Verification (UNIT_CYCLES=4, CARRIER_HALF=2 for simulation)
REQ-027 SHALL verify: reset, then start with custom_code=8'h00 and data_in=8'h16 -> ir_out envelope high 64 cycles, low 32, then bit marks/spaces decoding to 32'hE9_16_FF_00; done is seen 484 cycles after the first mark.
REQ-028 SHALL verify: start with custom_code=8'hA5 and data_in=8'h3C -> decoded word 32'hC3_3C_5A_A5; busy high for exactly 484 cycles.
REQ-029 SHALL verify: start re-pulsed at cycles 10 and 200 of a frame -> both ignored, only one frame sent, and done pulses once.
REQ-030 SHALL verify: start held high through the done cycle -> a second frame begins on the next edge, and busy low for exactly 1 cycle.
REQ-031 SHALL verify: rst_n pulled low in the middle of BIT_SPACE -> ir_out, busy and done go 0 the same cycle; after release, with no start, ir_out stays 0.
REQ-032 SHALL verify: with IRDA_TX_CARRIER_EN defined -> during LEAD_MARK, ir_out toggles every 2 cycles starting high; during spaces it stays 0.
